// File: rtl/ram_fill_check.sv
// ram_fill_check: BIST initiator for a single-port synchronous RAM.
// Fills every address {a,b} with a+b, reads all addresses back and compares
// each registered read word against the expected sum. Reports a mismatch
// count, a sticky error flag and the first failing address.
// Optional build macro FILL_CHECK_STOP_ON_ERR_EN: abandon readback on the
// first mismatch and go straight to DONE.
module ram_fill_check #(
  parameter  int unsigned HALF_W = 4,
  parameter  int unsigned DATA_W = 5,
  parameter  int unsigned CNT_W  = 9,
  localparam int unsigned ADDR_W = 2 * HALF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              err_flag,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                go_q, go_d;
  logic                cs_q, cs_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_flag_q, err_flag_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic                pv_q, pv_d;
  logic [ADDR_W-1:0]   pa_q, pa_d;
  logic                mismatch;

  function automatic logic [DATA_W-1:0] sum_of(input logic [ADDR_W-1:0] a);
    return DATA_W'(a[ADDR_W-1:HALF_W]) + DATA_W'(a[HALF_W-1:0]);
  endfunction

  // Compare the word returned for the read issued in the previous cycle.
  always_comb begin
    mismatch = pv_q && (state_q == S_READ || state_q == S_DRAIN) &&
               (ram_rdata != sum_of(pa_q));
  end

  // Next-state logic; bus outputs are computed from the next state so that
  // they come straight out of flops. An accepted start is held in go_q for
  // one cycle before FILL begins.
  always_comb begin
    state_d    = state_q;
    go_d       = 1'b0;
    addr_d     = addr_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    first_d    = first_q;
    pv_d       = cs_q && !we_q;
    pa_d       = addr_q;

    if (mismatch) begin
      err_cnt_d  = err_cnt_q + CNT_W'(1);
      err_flag_d = 1'b1;
      if (err_cnt_q == '0) first_d = pa_q;
    end

    case (state_q)
      S_IDLE: begin
        if (go_q) begin
          state_d = S_FILL;
          addr_d  = '0;
        end else if (start) begin
          go_d       = 1'b1;
          err_cnt_d  = '0;
          err_flag_d = 1'b0;
          first_d    = '0;
        end
      end
      S_FILL: begin
        if (addr_q == '1) begin
          state_d = S_READ;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_READ: begin
        if (addr_q == '1) begin
          state_d = S_DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef FILL_CHECK_STOP_ON_ERR_EN
    if (mismatch) state_d = S_DONE;
`endif

    cs_d    = (state_d == S_FILL) || (state_d == S_READ);
    we_d    = (state_d == S_FILL);
    wdata_d = we_d ? sum_of(addr_d) : '0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State, bus, status and read-pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      go_q       <= 1'b0;
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
      first_q    <= '0;
      pv_q       <= 1'b0;
      pa_q       <= '0;
    end else begin
      state_q    <= state_d;
      go_q       <= go_d;
      cs_q       <= cs_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
      first_q    <= first_d;
      pv_q       <= pv_d;
      pa_q       <= pa_d;
    end
  end

  assign ram_cs         = cs_q;
  assign ram_we         = we_q;
  assign ram_addr       = addr_q;
  assign ram_wdata      = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_flag       = err_flag_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_ram_fill_check.sv
// Directed bench for ram_fill_check with a behavioural RAM model that can
// inject read faults.
module tb_ram_fill_check;

`ifdef FILL_CHECK_STOP_ON_ERR_EN
  localparam int STOP = 1;
`else
  localparam int STOP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ram_cs, ram_we;
  logic [7:0] ram_addr;
  logic [4:0] ram_wdata;
  logic [4:0] ram_rdata;
  logic       busy, done, err_flag;
  logic [8:0] err_cnt;
  logic [7:0] first_err_addr;

  logic [4:0] mem [256];
  int         fault_mode = 0;
  int         vectors = 0;
  int         miscompares = 0;

  ram_fill_check #(.HALF_W(4), .DATA_W(5), .CNT_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .done(done), .err_flag(err_flag),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  // 1: flip bit0 at 0x5B; 2: bit4 stuck-at-0; 3: flip bit0 at 0x10
  function automatic logic [4:0] faulty(input logic [4:0] v, input logic [7:0] a);
    logic [4:0] r;
    r = v;
    if (fault_mode == 1 && a == 8'h5B) r[0] = ~r[0];
    if (fault_mode == 2) r[4] = 1'b0;
    if (fault_mode == 3 && a == 8'h10) r[0] = ~r[0];
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_cs && !ram_we) ram_rdata <= faulty(mem[ram_addr], ram_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns #1 after the edge that samples start.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int first, output int lat);
    lat = first;
    while (!done && lat < 600) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input int fm, input int exp_lat, input int exp_cnt,
                     input int exp_first, input string tag);
    int lat;
    fault_mode = fm;
    do_start();
    wait_done(0, lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_err_cnt"}, err_cnt, exp_cnt);
    check({tag, "_err_flag"}, err_flag, (exp_cnt != 0) ? 1 : 0);
    check({tag, "_first_err"}, first_err_addr, exp_first);
    @(posedge clk);
    #1;
    check({tag, "_done_1cyc"}, done, 0);
    check({tag, "_busy_off"}, busy, 0);
  endtask

  initial begin
    int lat;
    int lat5;
    int dcount;
    int found;

    start = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_cs", ram_cs, 0);
    check("rst_we", ram_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_flag", err_flag, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_first", first_err_addr, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: async reset in the middle of FILL
    do_start();
    found = 0;
    for (int n = 0; n < 300 && found == 0; n++) begin
      @(posedge clk);
      #1;
      if (ram_cs && ram_we && ram_addr == 8'h40) found = 1;
    end
    check("t1_reach_40", found, 1);
    check("t1_wdata_40", ram_wdata, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_cs", ram_cs, 0);
    check("t1_we", ram_we, 0);
    check("t1_busy", busy, 0);
    check("t1_done", done, 0);
    check("t1_err_cnt", err_cnt, 0);
    check("t1_addr", ram_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    check("t1_accept_cs", ram_cs, 0);
    @(posedge clk);
    #1;
    check("t1_restart_cs", ram_cs, 1);
    check("t1_restart_we", ram_we, 1);
    check("t1_restart_addr", ram_addr, 0);
    check("t1_restart_busy", busy, 1);
    wait_done(1, lat);
    check("t1_latency", lat, 514);
    @(posedge clk);
    #1;

    // 2: fault-free
    run(0, 514, 0, 0, "t2");
    check("t2_mem_2A", mem[8'h2A], 12);
    check("t2_mem_FF", mem[8'hFF], 30);

    // 3: single flipped bit at 0x5B
    run(1, STOP ? 350 : 514, 1, 8'h5B, "t3");

    // 4: bit4 stuck-at-0
    run(2, STOP ? 290 : 514, STOP ? 1 : 120, 8'h1F, "t4");

    // 5: start pulses mid-FILL and in the DONE cycle are ignored
    fault_mode = 1;
    do_start();
    lat5 = -1;
    dcount = 0;
    for (int n = 1; n <= 530; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        dcount++;
        if (lat5 < 0) lat5 = n;
        start = 1'b1;
      end else if (ram_cs && ram_we && ram_addr == 8'h80) begin
        start = 1'b1;
      end
    end
    start = 1'b0;
    check("t5_done_count", dcount, 1);
    check("t5_latency", lat5, STOP ? 350 : 514);
    check("t5_busy_idle", busy, 0);
    check("t5_err_cnt", err_cnt, 1);
    check("t5_err_flag", err_flag, 1);
    check("t5_first_err", first_err_addr, 8'h5B);

    // 6: fault at 0x10; a fresh start clears the status first
    fault_mode = 3;
    do_start();
    check("t6_clear_cnt", err_cnt, 0);
    check("t6_clear_flag", err_flag, 0);
    check("t6_clear_first", first_err_addr, 0);
    found = 0;
    for (int n = 0; n < 600 && found == 0; n++) begin
      @(posedge clk);
      #1;
      if (ram_cs && !ram_we && ram_addr == 8'h10) found = 1;
    end
    check("t6_issue_10", found, 1);
    @(posedge clk);
    #1;
    check("t6_e1_done", done, 0);
    check("t6_e1_cs", ram_cs, 1);
    @(posedge clk);
    #1;
    check("t6_e2_done", done, STOP);
    check("t6_e2_cs", ram_cs, STOP ? 0 : 1);
    check("t6_e2_err_cnt", err_cnt, 1);
    check("t6_e2_first", first_err_addr, 8'h10);
    @(posedge clk);
    #1;
    check("t6_e3_cs", ram_cs, STOP ? 0 : 1);
    found = 0;
    for (int n = 0; n < 600 && found == 0; n++) begin
      if (!busy) found = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("t6_finish", found, 1);
    check("t6_final_cs", ram_cs, 0);
    check("t6_final_cnt", err_cnt, 1);
    check("t6_final_first", first_err_addr, 8'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
